// File: rtl/riscv_pkg.sv
// Shared RISC-V opcode constants and the fetch-unit state type.
package riscv_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_NOP    = 7'b0010011;

  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StDrain,
    StHold
  } fetch_state_e;

  function automatic logic is_ctrl_op(input logic [31:0] instr);
    return (instr[6:0] == OP_BRANCH) || (instr[6:0] == OP_JAL) || (instr[6:0] == OP_JALR);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with single-cycle flush, occupancy count and full/empty flags.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic             push_en, pop_en;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push_en && !pop_en) begin
        count_d = count_q + (PtrW + 1)'(1);
      end else if (pop_en && !push_en) begin
        count_d = count_q - (PtrW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; empty gates everything read out of it.
  always_ff @(posedge clk) begin
    if (push_en && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction-fetch front end: sequential word fetch, prefetch queue, control-flow stall
// and redirect flush.
module instr_fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter bit          STALL_ON_CTRL = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   mem_req_valid,
  output logic [31:0]            mem_req_addr,
  input  logic                   mem_req_ready,
  input  logic                   mem_resp_valid,
  input  logic [31:0]            mem_resp_data,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   ctrl_resolved,
  output logic                   out_valid,
  output logic [31:0]            out_instr,
  output logic [31:0]            out_pc,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fill_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         run_q;
  logic         accept, outstanding, push, pop;
  logic         fifo_full, fifo_empty;
  logic [63:0]  fifo_rdata;
  logic         unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // run_q keeps the request line low while reset is held; everything here is registered.
  assign mem_req_valid = run_q && (state_q == StFetch) && !fifo_full;
  assign mem_req_addr  = pc_q;
  assign accept        = mem_req_valid && mem_req_ready;
  assign outstanding   = (state_q == StWait) || (state_q == StDrain);
  assign push          = (state_q == StWait) && mem_resp_valid && !redirect_valid;
  assign pop           = out_valid && out_ready;
  assign out_valid     = !fifo_empty;
  assign out_pc        = fifo_rdata[63:32];
  assign out_instr     = fifo_rdata[31:0];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
      // A request still in flight must have its response swallowed before fetch restarts.
      if ((outstanding && !mem_resp_valid) || accept) begin
        state_d = StDrain;
      end else begin
        state_d = StFetch;
      end
    end else begin
      unique case (state_q)
        StFetch: begin
          if (accept) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = StWait;
          end
        end
        StWait: begin
          if (mem_resp_valid) begin
            if (STALL_ON_CTRL && is_ctrl_op(mem_resp_data)) begin
              state_d = StHold;
            end else begin
              state_d = StFetch;
            end
          end
        end
        StHold: begin
          if (ctrl_resolved) state_d = StFetch;
        end
        StDrain: begin
          if (mem_resp_valid) state_d = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      run_q    <= 1'b1;
    end
  end

  fetch_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .wdata ({req_pc_q, mem_resp_data}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fill_count)
  );

endmodule
